// File: rtl/fc_layer.sv
// fc_layer: L-channel x P-beat fully-connected stage producing K saturated class scores serially; define FC_ARGMAX_EN to build the argmax class_id
module fc_layer #(
  parameter int L     = 5,
  parameter int P     = 4,
  parameter int K     = 3,
  parameter int DW    = 13,
  parameter int WW    = 8,
  parameter int AW    = 32,
  parameter int SHIFT = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DW-1:0]         in0,
  input  logic signed [DW-1:0]         in1,
  input  logic signed [DW-1:0]         in2,
  input  logic signed [DW-1:0]         in3,
  input  logic signed [DW-1:0]         in4,
  input  logic                         w_wr,
  input  logic [$clog2(K*L*P+K)-1:0]   w_addr,
  input  logic signed [WW-1:0]         w_data,
  output logic                         out_valid,
  output logic [$clog2(K)-1:0]         out_idx,
  output logic signed [DW-1:0]         out_data,
  output logic [$clog2(K)-1:0]         class_id,
  output logic                         done
);
  localparam int NW  = K*L*P + K;
  localparam int ABW = $clog2(NW);
  localparam int KW  = $clog2(K);
  localparam int PW  = P > 1 ? $clog2(P) : 1;
  localparam int MW  = DW + WW;
  localparam logic [PW-1:0] P_LAST = PW'(P - 1);
  localparam logic [KW-1:0] K_LAST = KW'(K - 1);
  localparam logic signed [AW-1:0] SMAX = AW'((1 << (DW-1)) - 1);
  localparam logic signed [AW-1:0] SMIN = AW'(-(1 << (DW-1)));

  typedef enum logic [2:0] {IDLE, ACCUM, SCALE, OUT, DONE} state_t;

  state_t state, state_n;
  logic signed [WW-1:0] mem [NW];
  logic signed [DW-1:0] in_v [L];
  logic signed [AW-1:0] acc [K];
  logic signed [AW-1:0] dot [K];
  logic signed [AW-1:0] r [K];
  logic signed [DW-1:0] sat [K];
  logic signed [DW-1:0] res [K];
  logic signed [MW-1:0] prod;
  logic [PW-1:0] p;
  logic [KW-1:0] kc;

  assign in_v = '{in0, in1, in2, in3, in4};

  always_ff @(posedge clk)
    if (state == IDLE && w_wr && 32'(w_addr) < NW) mem[w_addr] <= w_data;

  always_comb begin
    prod = '0;
    dot  = '{default: '0};
    for (int k = 0; k < K; k++)
      for (int c = 0; c < L; c++) begin
        prod   = MW'(mem[ABW'(k*L*P + c*P) + ABW'(p)]) * MW'(in_v[c]);
        dot[k] = dot[k] + AW'(prod);
      end
  end

  always_comb begin
    r   = '{default: '0};
    sat = '{default: '0};
    for (int k = 0; k < K; k++) begin
      r[k]   = (acc[k] + AW'(mem[ABW'(K*L*P + k)])) >>> SHIFT;
      sat[k] = r[k] > SMAX ? DW'(SMAX) : r[k] < SMIN ? DW'(SMIN) : DW'(r[k]);
    end
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= state_n;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? ACCUM : IDLE;
      ACCUM:   state_n = in_valid && p == P_LAST ? SCALE : ACCUM;
      SCALE:   state_n = OUT;
      OUT:     state_n = kc == K_LAST ? DONE : OUT;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      acc <= '{default: '0};
      res <= '{default: '0};
      p   <= '0;
      kc  <= '0;
    end else begin
      if (state == IDLE && start) begin
        acc <= '{default: '0};
        p   <= '0;
      end
      if (state == ACCUM && in_valid) begin
        for (int k = 0; k < K; k++) acc[k] <= acc[k] + dot[k];
        p <= p + 1'b1;
      end
      if (state == SCALE) begin
        res <= sat;
        kc  <= '0;
      end
      if (state == OUT) kc <= kc + 1'b1;
    end

  always_comb begin
    in_ready  = state == ACCUM;
    out_valid = state == OUT;
    out_idx   = state == OUT ? kc : '0;
    out_data  = state == OUT ? res[kc] : '0;
    done      = state == DONE;
  end

`ifdef FC_ARGMAX_EN
  logic [KW-1:0] best;
  always_comb begin
    best = '0;
    for (int k = 1; k < K; k++) if (res[k] > res[best]) best = KW'(k);
  end
  assign class_id = state == DONE ? best : '0;
`else
  assign class_id = '0;
`endif
endmodule

// File: tb/tb_fc_layer.sv
// tb_fc_layer: randomized self-checking bench comparing SHIFT=0 and SHIFT=2 fc_layer instances against an arithmetic model
module tb_fc_layer;
  localparam int L = 5, P = 4, K = 3, DW = 13, WW = 8;
  localparam int NW = K*L*P + K, ABW = $clog2(NW), KW = $clog2(K);
  localparam int SMAX = (1 << (DW-1)) - 1, SMIN = -(1 << (DW-1));
  logic clk = 0, rst = 0, start = 0, in_valid = 0, w_wr = 0;
  logic signed [DW-1:0] in_v [L];
  logic [ABW-1:0] w_addr = '0;
  logic signed [WW-1:0] w_data = '0;
  logic in_ready [2], out_valid [2], done [2];
  logic [KW-1:0] out_idx [2], class_id [2];
  logic signed [DW-1:0] out_data [2];
  int n_cmp = 0, n_bad = 0;
  int w [K][L][P];
  int b [K];
  int x [P][L];
  int e [2][K];

  always #5 clk = ~clk;

  for (genvar i = 0; i < 2; i++) begin : g_dut
    fc_layer #(.SHIFT(2*i)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready[i]),
      .in0(in_v[0]), .in1(in_v[1]), .in2(in_v[2]), .in3(in_v[3]), .in4(in_v[4]),
      .w_wr(w_wr), .w_addr(w_addr), .w_data(w_data),
      .out_valid(out_valid[i]), .out_idx(out_idx[i]), .out_data(out_data[i]),
      .class_id(class_id[i]), .done(done[i])
    );
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int score(int k, int sh);
    longint a = b[k];
    for (int p = 0; p < P; p++)
      for (int c = 0; c < L; c++) a += longint'(w[k][c][p]) * x[p][c];
    a = a >>> sh;
    return a > SMAX ? SMAX : a < SMIN ? SMIN : int'(a);
  endfunction

  function automatic int amax(int d);
    int m = 0;
`ifdef FC_ARGMAX_EN
    for (int k = 1; k < K; k++) if (e[d][k] > e[d][m]) m = k;
`endif
    return m;
  endfunction

  task automatic fill(input int wv, input int bv);
    for (int k = 0; k < K; k++) begin
      b[k] = bv;
      for (int c = 0; c < L; c++)
        for (int p = 0; p < P; p++) w[k][c][p] = wv;
    end
  endtask

  task automatic xfill(input int v);
    for (int p = 0; p < P; p++)
      for (int c = 0; c < L; c++) x[p][c] = v;
  endtask

  task automatic load();
    for (int a = 0; a < NW; a++) begin
      w_wr = 1;
      w_addr = ABW'(a);
      w_data = a < K*L*P ? WW'(w[a/(L*P)][(a/P)%L][a%P]) : WW'(b[a-K*L*P]);
      @(negedge clk);
    end
    w_wr = 0;
  endtask

  task automatic run(input string tag, input int gap, input bit junk, input bit poke);
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < K; k++) e[d][k] = score(k, 2*d);
    start = 1;
    @(negedge clk);
    start = 0;
    for (int d = 0; d < 2; d++) check({tag, " in_ready"}, in_ready[d], 1);
    for (int p = 0; p < P; p++) begin
      repeat ($urandom_range(gap, 0)) begin
        in_valid = 0;
        for (int c = 0; c < L; c++) in_v[c] = DW'($urandom);
        if (junk) begin
          w_wr = 1;
          w_addr = ABW'($urandom_range(NW-1, 0));
          w_data = WW'($urandom);
        end
        @(negedge clk);
      end
      in_valid = 1;
      for (int c = 0; c < L; c++) in_v[c] = DW'(x[p][c]);
      @(negedge clk);
    end
    in_valid = 0;
    w_wr = 0;
    for (int d = 0; d < 2; d++) check({tag, " scale out_valid"}, out_valid[d], 0);
    for (int k = 0; k < K; k++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        check({tag, " out_valid"}, out_valid[d], 1);
        check({tag, " out_idx"}, out_idx[d], k);
        check($sformatf("%s out_data[%0d] sh%0d", tag, k, 2*d), out_data[d], e[d][k]);
        check({tag, " done early"}, done[d], 0);
      end
      start = poke && k == 1;
    end
    @(negedge clk);
    start = 0;
    for (int d = 0; d < 2; d++) begin
      check({tag, " done"}, done[d], 1);
      check({tag, " class_id"}, class_id[d], amax(d));
      check({tag, " done out_valid"}, out_valid[d], 0);
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check({tag, " idle done"}, done[d], 0);
      check({tag, " idle in_ready"}, in_ready[d], 0);
      check({tag, " idle class_id"}, class_id[d], 0);
    end
  endtask

  initial begin
    for (int c = 0; c < L; c++) in_v[c] = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst in_ready", in_ready[d], 0);
      check("rst out_valid", out_valid[d], 0);
      check("rst out_idx", out_idx[d], 0);
      check("rst out_data", out_data[d], 0);
      check("rst class_id", class_id[d], 0);
      check("rst done", done[d], 0);
    end
    rst = 1;
    @(negedge clk);
    fill(1, 0); xfill(1); load();
    run("base", 0, 0, 0);
    for (int c = 0; c < L; c++)
      for (int p = 0; p < P; p++) w[2][c][p] = 2;
    b[1] = 30; load();
    run("bias", 0, 0, 0);
    fill(127, 0); xfill(4095); load();
    run("sat_hi", 0, 0, 0);
    fill(-128, 0); load();
    run("sat_lo", 0, 0, 0);
    fill(0, 0); xfill(1);
    for (int k = 0; k < K; k++) w[k][0][0] = -21;
    load();
    run("neg", 0, 0, 0);
    fill(1, 0); xfill(1); load();
    run("gaps", 3, 1, 1);
    run("after_junk", 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < K; k++) begin
        b[k] = int'($urandom_range(255, 0)) - 128;
        for (int c = 0; c < L; c++)
          for (int p = 0; p < P; p++) w[k][c][p] = int'($urandom_range(255, 0)) - 128;
      end
      for (int p = 0; p < P; p++)
        for (int c = 0; c < L; c++) x[p][c] = int'($urandom_range(8191, 0)) - 4096;
      load();
      run($sformatf("rnd%0d", i), 2, 1, 0);
    end
    fill(1, 0); xfill(1); load();
    start = 1;
    @(negedge clk);
    start = 0;
    in_valid = 1;
    for (int c = 0; c < L; c++) in_v[c] = 1;
    repeat (2) @(negedge clk);
    in_valid = 0;
    #2 rst = 0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check("abort in_ready", in_ready[d], 0);
      check("abort out_valid", out_valid[d], 0);
      check("abort out_idx", out_idx[d], 0);
      check("abort out_data", out_data[d], 0);
      check("abort class_id", class_id[d], 0);
      check("abort done", done[d], 0);
    end
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) check("abort stays idle", in_ready[d], 0);
    run("post_rst", 1, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
